// File: rtl/rx_demap_ctrl.sv
// Receive-side sequencer for the 7-lane symbol demapper.
// Frames incoming symbol triplets and flags illegal flip codes. Each triplet
// is presented to an external combinational demapper. The 16-bit result is
// returned on a valid/ready stream tagged with frame-last and error.
module rx_demap_ctrl #(
  parameter int unsigned FRAME_WORDS = 64,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_sof,
  input  logic [6:0]           s_flip,
  input  logic [6:0]           s_rotation,
  input  logic [6:0]           s_polarity,
  output logic [6:0]           dm_flip,
  output logic [6:0]           dm_rotation,
  output logic [6:0]           dm_polarity,
  input  logic [15:0]          dm_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [15:0]          m_data,
  output logic                 m_last,
  output logic                 m_err,
  output logic                 frame_abort,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int unsigned LANE_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS + 1) : 1;
  localparam logic [LANE_W-1:0] BAD_PAIR = LANE_W'(7'h60);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Control state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Stage 1: accepted triplet plus tags
  logic               s1_v_q, s1_v_d;
  logic [LANE_W-1:0]  s1_flip_q, s1_rot_q, s1_pol_q;
  logic               s1_legal_q, s1_last_q;

  // Stage 2: captured demapper result plus tags
  logic               s2_v_q, s2_v_d;
  logic [DATA_W-1:0]  m_data_q;
  logic               m_last_q, m_err_q;

  logic [ERR_CNT_W-1:0] err_q, err_d;

  // Combinational handshake and decision signals
  logic               adv2_c;
  logic               accept_c;
  logic               xfer_c;
  logic               legal_c;
  logic               keep_c;
  logic               last_c;
  logic               abort_c;
  logic [1:0]         err_inc_c;
  logic [ERR_CNT_W:0] err_sum_c;

  // Flip-code legality: at most two lanes flipped, excluding the reserved pair
  always_comb begin
    legal_c = ($countones(s_flip) <= 2) && (s_flip != BAD_PAIR);
  end

  // Stage-advance and input handshake
  always_comb begin
    adv2_c   = !s2_v_q || m_ready;
    s_ready  = !rst && en && (!s1_v_q || adv2_c);
    accept_c = s_valid && s_ready;
    xfer_c   = s1_v_q && adv2_c;
  end

  // Framing FSM: decides whether an accepted symbol is kept and how it is tagged
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    keep_c  = 1'b0;
    last_c  = 1'b0;
    abort_c = 1'b0;
    if (accept_c) begin
      unique case (state_q)
        IDLE: begin
          if (s_sof) begin
            keep_c  = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = RUN;
          end
        end
        RUN: begin
          keep_c = 1'b1;
          if (s_sof) begin
            abort_c = 1'b1;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            last_c  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage-valid next values
  always_comb begin
    s1_v_d = s1_v_q;
    if (keep_c) begin
      s1_v_d = 1'b1;
    end else if (xfer_c) begin
      s1_v_d = 1'b0;
    end
    s2_v_d = s2_v_q;
    if (xfer_c) begin
      s2_v_d = 1'b1;
    end else if (m_ready) begin
      s2_v_d = 1'b0;
    end
  end

  // Saturating error counter: one per illegal kept word, one per abort
  always_comb begin
    err_inc_c = 2'(keep_c && !legal_c) + 2'(abort_c);
    err_sum_c = {1'b0, err_q} + (ERR_CNT_W + 1)'(err_inc_c);
    err_d     = err_sum_c[ERR_CNT_W] ? '1 : err_sum_c[ERR_CNT_W-1:0];
  end

  // FSM state and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage 1 registers; payload only changes when a kept symbol is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_flip_q  <= '0;
      s1_rot_q   <= '0;
      s1_pol_q   <= '0;
      s1_legal_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (keep_c) begin
        s1_flip_q  <= s_flip;
        s1_rot_q   <= s_rotation;
        s1_pol_q   <= s_polarity;
        s1_legal_q <= legal_c;
        s1_last_q  <= last_c;
      end
    end
  end

  // Stage 2 registers; illegal words are zeroed and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q   <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      m_err_q  <= 1'b0;
    end else begin
      s2_v_q <= s2_v_d;
      if (xfer_c) begin
        m_data_q <= s1_legal_q ? dm_data : '0;
        m_last_q <= s1_last_q;
        m_err_q  <= !s1_legal_q;
      end
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign dm_flip     = s1_flip_q;
  assign dm_rotation = s1_rot_q;
  assign dm_polarity = s1_pol_q;
  assign m_valid     = s2_v_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign m_err       = m_err_q;
  assign frame_abort = abort_c;
  assign err_cnt     = err_q;
  assign busy        = (state_q == RUN) || s1_v_q || s2_v_q;

endmodule

// File: tb/tb_rx_demap_ctrl.sv
// Self-checking bench for rx_demap_ctrl: directed scenarios followed by a
// randomized run, all compared against a transaction-level frame model.
module tb_rx_demap_ctrl;

  localparam int unsigned FW = 4;
  localparam int unsigned EW = 2;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, s_valid, s_ready, s_sof;
  logic [6:0]    s_flip, s_rotation, s_polarity;
  logic [6:0]    dm_flip, dm_rotation, dm_polarity;
  logic [15:0]   dm_data;
  logic          m_valid, m_ready, m_last, m_err, frame_abort, busy;
  logic [15:0]   m_data;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  // Stand-in for the external demapper: any bit-mixing function of the triplet
  function automatic logic [15:0] demap(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p);
    return {r ^ {f[3:0], f[6:4]}, p ^ f, 2'b01};
  endfunction

  assign dm_data = demap(dm_flip, dm_rotation, dm_polarity);

  rx_demap_ctrl #(.FRAME_WORDS(FW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_flip(s_flip), .s_rotation(s_rotation), .s_polarity(s_polarity),
    .dm_flip(dm_flip), .dm_rotation(dm_rotation), .dm_polarity(dm_polarity),
    .dm_data(dm_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_err(m_err), .frame_abort(frame_abort),
    .err_cnt(err_cnt), .busy(busy)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   in_frame = 0;
  int   words = 0;
  int   exp_err = 0;
  bit   last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [6:0] f);
    int n = 0;
    for (int i = 0; i < 7; i++) n += int'(f[i]);
    return (n <= 2) && (f != 7'h60);
  endfunction

  // One clock: check combinational/stream outputs, advance model, check registers
  task automatic tick();
    bit   exp_rdy, acc, abort_e, ill, kept, mv, was_rst;
    exp_t e;
    #1;
    exp_rdy = !rst && en && ((q.size() < 2) || m_ready);
    chk("s_ready", s_ready, exp_rdy);
    acc     = s_valid && exp_rdy;
    abort_e = acc && in_frame && s_sof;
    chk("frame_abort", frame_abort, abort_e);
    mv = (q.size() > 0) && (cyc >= q[0].acc + 2);
    chk("m_valid", m_valid, mv);
    if (mv) begin
      chk("m_data", m_data, q[0].data);
      chk("m_last", m_last, q[0].last);
      chk("m_err", m_err, q[0].err);
      if (m_ready && !rst) void'(q.pop_front());
    end
    kept = 0;
    ill  = !legal(s_flip);
    e.data = ill ? 16'h0000 : demap(s_flip, s_rotation, s_polarity);
    e.err  = ill;
    e.last = 0;
    e.acc  = cyc;
    if (acc) begin
      if (!in_frame) begin
        if (s_sof) begin
          in_frame = 1;
          words    = 1;
          kept     = 1;
        end
      end else begin
        kept  = 1;
        words = s_sof ? 1 : words + 1;
        if (words == FW) begin
          e.last   = 1;
          in_frame = 0;
          words    = 0;
        end
      end
      if (kept) q.push_back(e);
      exp_err += int'(kept && ill) + int'(abort_e);
      if (exp_err > ERR_MAX) exp_err = ERR_MAX;
    end
    last_acc = acc;
    was_rst  = rst;
    @(posedge clk);
    cyc++;
    if (was_rst) begin
      q.delete();
      in_frame = 0;
      words    = 0;
      exp_err  = 0;
    end
    @(negedge clk);
    chk("err_cnt", err_cnt, exp_err);
    chk("busy", busy, in_frame || (q.size() > 0));
    if (was_rst) begin
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_err", m_err, 0);
      chk("rst_dm", {dm_flip, dm_rotation, dm_polarity}, 0);
    end
  endtask

  // Offer one symbol until accepted (bounded), then drop s_valid
  task automatic send(input logic sof, input logic [6:0] f, input logic [6:0] r, input logic [6:0] p);
    s_valid = 1; s_sof = sof; s_flip = f; s_rotation = r; s_polarity = p;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    s_valid = 0; s_sof = 0;
  endtask

  task automatic idle(input int n);
    s_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1; s_valid = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; en = 0; s_valid = 0; s_sof = 0; m_ready = 1;
    s_flip = '0; s_rotation = '0; s_polarity = '0;
    tick();
    tick();
    rst = 0; en = 1;

    // First word of a frame: latency and pass-through of demapper result
    send(1, 7'h00, 7'h05, 7'h0A);
    chk("dm_flip", dm_flip, 7'h00);
    chk("dm_rotation", dm_rotation, 7'h05);
    chk("dm_polarity", dm_polarity, 7'h0A);
    idle(3);

    // Complete frame back-to-back, last on fourth word, then drain to idle
    do_reset();
    send(1, 7'h01, 7'h11, 7'h22);
    send(0, 7'h03, 7'h33, 7'h44);
    send(0, 7'h00, 7'h55, 7'h66);
    send(0, 7'h50, 7'h77, 7'h01);
    idle(4);
    chk("busy_after_frame", busy, 0);

    // Illegal codes zeroed and counted, legal 0x50 passes; then saturation
    do_reset();
    send(1, 7'h00, 7'h12, 7'h34);
    send(0, 7'h60, 7'h12, 7'h34);
    send(0, 7'h07, 7'h56, 7'h78);
    send(0, 7'h50, 7'h1F, 7'h2E);
    idle(3);
    chk("err_two_illegal", err_cnt, 2);
    send(1, 7'h7F, 7'h01, 7'h02);
    send(0, 7'h7F, 7'h03, 7'h04);
    send(1, 7'h7F, 7'h05, 7'h06);
    idle(3);
    chk("err_saturated", err_cnt, 3);

    // Backpressure: two words fill the pipe, third stalls until m_ready
    do_reset();
    m_ready = 0;
    send(1, 7'h02, 7'h0C, 7'h0D);
    send(0, 7'h04, 7'h0E, 7'h0F);
    s_valid = 1; s_sof = 0; s_flip = 7'h08; s_rotation = 7'h10; s_polarity = 7'h20;
    tick();
    tick();
    tick();
    m_ready = 1;
    tick();
    s_valid = 0;
    idle(4);

    // Non-sof symbols in IDLE dropped; premature sof aborts and restarts frame
    do_reset();
    send(0, 7'h01, 7'h01, 7'h01);
    send(0, 7'h7F, 7'h02, 7'h02);
    send(0, 7'h02, 7'h03, 7'h03);
    idle(2);
    send(1, 7'h00, 7'h04, 7'h04);
    send(0, 7'h01, 7'h05, 7'h05);
    send(1, 7'h02, 7'h06, 7'h06);
    send(0, 7'h03, 7'h07, 7'h07);
    send(0, 7'h05, 7'h08, 7'h08);
    send(0, 7'h06, 7'h09, 7'h09);
    idle(3);

    // Reset in the middle of a frame
    send(1, 7'h10, 7'h0A, 7'h0B);
    s_valid = 1; s_sof = 0; s_flip = 7'h20;
    tick();
    rst = 1;
    tick();
    rst = 0; s_valid = 0;
    idle(3);

    // Randomized traffic, including en/m_ready stalls and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 9) < 7);
      s_valid = ($urandom_range(0, 9) < 7);
      s_sof   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) begin
        s_flip = 7'($urandom);
      end else begin
        s_flip = 7'((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7)));
      end
      s_rotation = 7'($urandom);
      s_polarity = 7'($urandom);
      tick();
    end
    rst = 0; en = 1; m_ready = 1; s_valid = 0; s_sof = 0;
    idle(6);
    chk("final_m_valid", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
